// File: rtl/boot_loader_if.sv
// Byte-stream ingress and memory write port of the boot loader.
// Handshake: a byte moves on a rising edge where byte_valid and byte_ready are both high;
// byte_data must be stable while byte_valid is high, and rst on that edge cancels the transfer.
interface boot_loader_if #(
  parameter int WORD = 16
);
  logic            byte_valid;
  logic [7:0]      byte_data;
  logic            byte_ready;
  logic            mem_we;
  logic [WORD-1:0] mem_addr;
  logic [WORD-1:0] mem_data;

  modport master (
    output byte_valid,
    output byte_data,
    input  byte_ready,
    input  mem_we,
    input  mem_addr,
    input  mem_data
  );

  modport slave (
    input  byte_valid,
    input  byte_data,
    output byte_ready,
    output mem_we,
    output mem_addr,
    output mem_data
  );
endinterface

// File: rtl/boot_loader.sv
// Loads a count-prefixed, XOR-checksummed byte image into memory, then releases the core via cpu_run.
// Define BOOT_CLEAR_EN to zero the unloaded tail of memory before cpu_run is raised.
module boot_loader #(
  parameter int WORD      = 16,
  parameter int MEM_DEPTH = 256,
  parameter int BASE_ADDR = 0
) (
  input  logic            clk,
  input  logic            rst,
  boot_loader_if.slave    bus,
  output logic            cpu_run,
  output logic            busy,
  output logic            load_error,
  output logic [WORD-1:0] words_loaded,
  output logic [2:0]      fsm_state
);

  typedef enum logic [2:0] {
    CNT_HI  = 3'd0,
    CNT_LO  = 3'd1,
    DATA_HI = 3'd2,
    DATA_LO = 3'd3,
    CHECK   = 3'd4,
    CLEAR   = 3'd5,
    DONE    = 3'd6,
    ERR     = 3'd7
  } state_t;

  localparam logic [31:0] DEPTH_U = MEM_DEPTH;

  state_t          state, state_nxt;
  logic [15:0]     count_q, count_nxt;
  logic [15:0]     new_count;
  logic [7:0]      hi_q, hi_nxt;
  logic [7:0]      checksum_q, checksum_nxt;
  logic            mem_we_q, mem_we_nxt;
  logic [WORD-1:0] mem_addr_q, mem_addr_nxt;
  logic [WORD-1:0] mem_data_q, mem_data_nxt;
  logic            run_nxt, busy_nxt, err_nxt;
  logic [WORD-1:0] words_nxt;
  logic [WORD-1:0] wr_off_q, wr_off_nxt;
  logic            ready, accept;
`ifdef BOOT_CLEAR_EN
  logic [WORD-1:0] clr_off_q, clr_off_nxt;
`endif

  assign bus.byte_ready = ready;
  assign bus.mem_we     = mem_we_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_data   = mem_data_q;
  assign fsm_state      = state;

  always_comb begin
    ready        = 1'b0;
    accept       = 1'b0;
    state_nxt    = state;
    count_nxt    = count_q;
    new_count    = {count_q[15:8], bus.byte_data};
    hi_nxt       = hi_q;
    checksum_nxt = checksum_q;
    mem_we_nxt   = 1'b0;
    mem_addr_nxt = mem_addr_q;
    mem_data_nxt = mem_data_q;
    run_nxt      = cpu_run;
    busy_nxt     = busy;
    err_nxt      = load_error;
    words_nxt    = words_loaded;
    wr_off_nxt   = wr_off_q;
`ifdef BOOT_CLEAR_EN
    clr_off_nxt  = clr_off_q;
`endif

    ready  = (state == CNT_HI) || (state == CNT_LO) || (state == DATA_HI) ||
             (state == DATA_LO) || (state == CHECK);
    accept = bus.byte_valid && ready;

    case (state)
      CNT_HI: begin
        if (accept) begin
          count_nxt = {bus.byte_data, 8'h00};
          busy_nxt  = 1'b1;
          state_nxt = CNT_LO;
        end
      end
      CNT_LO: begin
        if (accept) begin
          count_nxt = new_count;
          // An oversized image is rejected before any payload is consumed.
          if ({16'h0000, new_count} > DEPTH_U) begin
            state_nxt = ERR;
            err_nxt   = 1'b1;
            busy_nxt  = 1'b0;
          end else if (new_count == 16'h0000) begin
            state_nxt = CHECK;
          end else begin
            state_nxt = DATA_HI;
          end
        end
      end
      DATA_HI: begin
        if (accept) begin
          hi_nxt       = bus.byte_data;
          checksum_nxt = checksum_q ^ bus.byte_data;
          state_nxt    = DATA_LO;
        end
      end
      DATA_LO: begin
        if (accept) begin
          checksum_nxt = checksum_q ^ bus.byte_data;
          mem_we_nxt   = 1'b1;
          mem_addr_nxt = WORD'(BASE_ADDR) + wr_off_q;
          mem_data_nxt = WORD'({hi_q, bus.byte_data});
          wr_off_nxt   = (wr_off_q == WORD'(MEM_DEPTH - 1)) ? '0 : wr_off_q + 1'b1;
          words_nxt    = words_loaded + 1'b1;
          if (32'(words_loaded) + 32'd1 == {16'h0000, count_q}) begin
            state_nxt = CHECK;
          end else begin
            state_nxt = DATA_HI;
          end
        end
      end
      CHECK: begin
        if (accept) begin
          if (bus.byte_data == checksum_q) begin
`ifdef BOOT_CLEAR_EN
            // The first clear write issues on this edge so mem_we is high for the whole CLEAR stay.
            if ({16'h0000, count_q} < DEPTH_U) begin
              state_nxt    = CLEAR;
              mem_we_nxt   = 1'b1;
              mem_addr_nxt = WORD'(BASE_ADDR) + WORD'(count_q);
              mem_data_nxt = '0;
              clr_off_nxt  = WORD'(count_q) + 1'b1;
            end else begin
              state_nxt = DONE;
              run_nxt   = 1'b1;
              busy_nxt  = 1'b0;
            end
`else
            state_nxt = DONE;
            run_nxt   = 1'b1;
            busy_nxt  = 1'b0;
`endif
          end else begin
            state_nxt = ERR;
            err_nxt   = 1'b1;
            busy_nxt  = 1'b0;
          end
        end
      end
`ifdef BOOT_CLEAR_EN
      CLEAR: begin
        if (32'(clr_off_q) >= DEPTH_U) begin
          state_nxt = DONE;
          run_nxt   = 1'b1;
          busy_nxt  = 1'b0;
        end else begin
          mem_we_nxt   = 1'b1;
          mem_addr_nxt = WORD'(BASE_ADDR) + clr_off_q;
          mem_data_nxt = '0;
          clr_off_nxt  = clr_off_q + 1'b1;
        end
      end
`endif
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= CNT_HI;
      count_q      <= '0;
      hi_q         <= '0;
      checksum_q   <= '0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= WORD'(BASE_ADDR);
      mem_data_q   <= '0;
      cpu_run      <= 1'b0;
      busy         <= 1'b0;
      load_error   <= 1'b0;
      words_loaded <= '0;
      wr_off_q     <= '0;
`ifdef BOOT_CLEAR_EN
      clr_off_q    <= '0;
`endif
    end else begin
      state        <= state_nxt;
      count_q      <= count_nxt;
      hi_q         <= hi_nxt;
      checksum_q   <= checksum_nxt;
      mem_we_q     <= mem_we_nxt;
      mem_addr_q   <= mem_addr_nxt;
      mem_data_q   <= mem_data_nxt;
      cpu_run      <= run_nxt;
      busy         <= busy_nxt;
      load_error   <= err_nxt;
      words_loaded <= words_nxt;
      wr_off_q     <= wr_off_nxt;
`ifdef BOOT_CLEAR_EN
      clr_off_q    <= clr_off_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_boot_loader.sv
// Directed bench for boot_loader: image-level model predicts every write and status output per cycle.
module tb_boot_loader;
  localparam int WORD      = 16;
  localparam int MEM_DEPTH = 256;
  localparam int BASE_ADDR = 0;
`ifdef BOOT_CLEAR_EN
  localparam int SETTLE = MEM_DEPTH + 8;
`else
  localparam int SETTLE = 4;
`endif

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            cpu_run, busy, load_error;
  logic [WORD-1:0] words_loaded;
  logic [2:0]      fsm_state;

  boot_loader_if #(.WORD(WORD)) bus ();

  boot_loader #(.WORD(WORD), .MEM_DEPTH(MEM_DEPTH), .BASE_ADDR(BASE_ADDR)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .cpu_run      (cpu_run),
    .busy         (busy),
    .load_error   (load_error),
    .words_loaded (words_loaded),
    .fsm_state    (fsm_state)
  );

  // clock / reset
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  // scoreboard state: entry = {is_data, due_cycle[30:0], addr[15:0], data[15:0]}
  logic [63:0] exp_q[$];
  logic [31:0] seen[$];
  logic [63:0] ent;
  int checks = 0;
  int errors = 0;
  int exp_words = 0;
  int run_at = -1, err_at = -1, busy_from = -1, busy_to = -1;
  bit chk_en = 1'b0;
  logic [7:0] img[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      if (exp_q.size() > 0 && exp_q[0][62:32] == 31'(cyc)) begin
        ent = exp_q.pop_front();
        if (ent[63]) exp_words++;
        check("mem_we", bus.mem_we, 1);
        check("mem_addr", bus.mem_addr, ent[31:16]);
        check("mem_data", bus.mem_data, ent[15:0]);
      end else begin
        check("mem_we_idle", bus.mem_we, 0);
      end
      if (bus.mem_we) seen.push_back({bus.mem_addr, bus.mem_data});
      check("words_loaded", words_loaded, exp_words);
      check("cpu_run", cpu_run, (run_at >= 0 && cyc >= run_at));
      check("load_error", load_error, (err_at >= 0 && cyc >= err_at));
      check("busy", busy, (busy_from >= 0 && cyc >= busy_from && (busy_to < 0 || cyc < busy_to)));
    end
  end

  // model helpers
  function automatic logic [7:0] payload_xor(input int n);
    logic [7:0] x = 8'h00;
    for (int i = 2; i < 2 + 2 * n && i < img.size(); i++) x ^= img[i];
    return x;
  endfunction

  // driver tasks
  task automatic do_reset(input bit with_valid);
    chk_en = 1'b0;
    rst = 1'b1;
    bus.byte_valid = with_valid;
    bus.byte_data = 8'h00;
    @(posedge clk); #1;
    rst = 1'b0;
    bus.byte_valid = 1'b0;
    exp_q.delete();
    seen.delete();
    exp_words = 0; run_at = -1; err_at = -1; busy_from = -1; busy_to = -1;
    chk_en = 1'b1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin @(posedge clk); #1; end
  endtask

  task automatic send_byte(input logic [7:0] b, output int e, output bit ok);
    bit rdy;
    int waited = 0;
    ok = 1'b0;
    bus.byte_valid = 1'b1;
    bus.byte_data = b;
    while (!ok && waited < 50) begin
      @(negedge clk); rdy = bus.byte_ready;
      @(posedge clk); #1;
      if (rdy) ok = 1'b1;
      waited++;
    end
    bus.byte_valid = 1'b0;
    e = cyc;
    if (!ok) begin
      checks++; errors++;
      $display("FAIL send_byte: byte %0h not accepted within 50 cycles", b);
    end
  endtask

  // Streams img; the model derives each expectation from the byte's position in the image.
  task automatic load_image(input int gap);
    int n, e;
    bit ok, too_big;
    logic [7:0] x;
    n = {img[0], img[1]};
    too_big = (n > MEM_DEPTH);
    x = payload_xor(n);
    for (int p = 0; p < img.size(); p++) begin
      send_byte(img[p], e, ok);
      if (!ok) return;
      if (p == 0) begin
        busy_from = e;
      end else if (p == 1 && too_big) begin
        err_at = e; busy_to = e;
        return;
      end else if (p >= 2 && p < 2 + 2 * n && ((p - 2) % 2) == 1) begin
        exp_q.push_back({1'b1, 31'(e), 16'(BASE_ADDR + (((p - 2) / 2) % MEM_DEPTH)), img[p-1], img[p]});
      end else if (p == 2 + 2 * n) begin
        if (img[p] == x) begin
`ifdef BOOT_CLEAR_EN
          for (int j = n; j < MEM_DEPTH; j++)
            exp_q.push_back({1'b0, 31'(e + j - n), 16'(BASE_ADDR + j), 16'h0000});
          run_at = e + (MEM_DEPTH - n);
`else
          run_at = e;
`endif
          busy_to = run_at;
        end else begin
          err_at = e; busy_to = e;
        end
        return;
      end
      for (int g = 0; g < gap; g++) begin @(posedge clk); #1; end
    end
  endtask

  task automatic check_reset_values(input string tag);
    @(negedge clk);
    check({tag, "_byte_ready"}, bus.byte_ready, 1);
    check({tag, "_mem_we"}, bus.mem_we, 0);
    check({tag, "_mem_addr"}, bus.mem_addr, BASE_ADDR);
    check({tag, "_mem_data"}, bus.mem_data, 0);
    check({tag, "_cpu_run"}, cpu_run, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_load_error"}, load_error, 0);
    check({tag, "_words_loaded"}, words_loaded, 0);
    check({tag, "_state"}, fsm_state, 0);
    @(posedge clk); #1;
  endtask

  task automatic poke_ignored(input int n);
    bus.byte_valid = 1'b1;
    bus.byte_data = 8'h5A;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check("ignored_byte_ready", bus.byte_ready, 0);
      @(posedge clk); #1;
    end
    bus.byte_valid = 1'b0;
  endtask

  initial begin
    bus.byte_valid = 1'b0;
    bus.byte_data = 8'h00;

    // reset state
    do_reset(1'b0);
    check_reset_values("reset");

    // good two-word image, back to back
    img = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h40};
    check("model_xor_pin", payload_xor(2), 8'h40);
    load_image(0);
    idle(SETTLE);
    check("t1_words", words_loaded, 2);
    check("t1_run", cpu_run, 1);
    check("t1_ready", bus.byte_ready, 0);
    check("t1_first_write", (seen.size() > 0) ? seen[0] : 32'hFFFF_FFFF, 32'h0000_1234);
    check("t1_second_write", (seen.size() > 1) ? seen[1] : 32'hFFFF_FFFF, 32'h0001_ABCD);
    poke_ignored(3);
    check("t1_queue_empty", exp_q.size(), 0);

    // bad checksum
    do_reset(1'b0);
    img = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h41};
    load_image(0);
    idle(4);
    check("t2_error", load_error, 1);
    check("t2_run", cpu_run, 0);
    check("t2_ready", bus.byte_ready, 0);
    poke_ignored(4);
    check("t2_words", words_loaded, 2);
    check("t2_state_err", fsm_state, 7);
    check("t2_queue_empty", exp_q.size(), 0);

    // oversized count
    do_reset(1'b0);
    img = '{8'h01, 8'h01, 8'h12, 8'h34};
    load_image(0);
    idle(2);
    check("t3_error", load_error, 1);
    check("t3_busy", busy, 0);
    check("t3_writes", seen.size(), 0);
    check("t3_words", words_loaded, 0);
    poke_ignored(3);

    // empty image
    do_reset(1'b0);
    img = '{8'h00, 8'h00, 8'h00};
    load_image(0);
    idle(SETTLE);
    check("t4_run", cpu_run, 1);
    check("t4_words", words_loaded, 0);
`ifdef BOOT_CLEAR_EN
    check("t4_writes", seen.size(), MEM_DEPTH);
`else
    check("t4_writes", seen.size(), 0);
`endif
    check("t4_queue_empty", exp_q.size(), 0);

    // gapped stream, reset mid-load with a byte pending, then a fresh image
    do_reset(1'b0);
    img = '{8'h00, 8'h02, 8'h12, 8'h34};
    load_image(1);
    idle(3);
    check("t5_partial_words", words_loaded, 1);
    check("t5_partial_busy", busy, 1);
    check("t5_partial_write", (seen.size() > 0) ? seen[0] : 32'hFFFF_FFFF, 32'h0000_1234);
    do_reset(1'b1);
    check_reset_values("midreset");
    img = '{8'h00, 8'h01, 8'hBE, 8'hEF, 8'h51};
    load_image(2);
    idle(SETTLE);
    check("t5_run", cpu_run, 1);
    check("t5_words", words_loaded, 1);
    check("t5_write", (seen.size() > 0) ? seen[0] : 32'hFFFF_FFFF, 32'h0000_BEEF);
    check("t5_queue_empty", exp_q.size(), 0);

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
